// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised up/down modulo counter with parallel load, count enable and
// three boundary modes (wrap, saturate, one-shot). Count range is 0..MAX_VAL.
// All arithmetic is modulo MAX_VAL+1, so q never exceeds MAX_VAL.
//
// Parameters:
//   WIDTH    counter width in bits (2..16)
//   MAX_VAL  highest count value (1 .. 2^WIDTH-1)
//   PRESCALE enabled cycles per count step (2..256); only used when the
//            macro MOD_COUNTER_PRESCALE_EN is defined
//
// Optional feature macro: MOD_COUNTER_PRESCALE_EN
//   Defined   : an internal prescaler divides enabled cycles by PRESCALE.
//   Undefined : q steps on every enabled cycle, PRESCALE is ignored.
//
// Ports:
//   clock     in   single clock, rising edge
//   clear     in   synchronous active-high reset
//   en        in   count enable
//   dir       in   1 = up, 0 = down
//   mode      in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   load      in   parallel load strobe (value clamped to MAX_VAL)
//   load_val  in   value to load
//   start     in   one-shot arm/restart strobe
//   q         out  current count (registered)
//   tc        out  terminal count (combinational)
//   wrap_p    out  one-cycle pulse after a wrap-around edge (registered)
//   ovf       out  sticky boundary-crossing flag (registered)
//   busy      out  one-shot RUN indicator (registered)
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 9,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_p,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;

    logic oneshot;
    logic saturate;
    logic start_ok;
    logic want_step;
    logic presc_term;
    logic step;
    logic at_top;
    logic at_bot;
    logic boundary;

    assign oneshot  = (mode == 2'b10);
    assign saturate = (mode == 2'b01);
    // A start strobe only matters in one-shot mode and is ignored while running.
    assign start_ok = oneshot && start && (state_reg != ST_RUN);
    // The counter would step this edge if nothing but the prescaler held it back.
    assign want_step = en && (!oneshot || (state_reg == ST_RUN));

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_reg, presc_next;

    assign presc_term = (presc_reg == PRESC_LAST);

    always_comb begin
        presc_next = presc_reg;
        if (load || start_ok) begin
            presc_next = '0;
        end else if (want_step) begin
            presc_next = presc_term ? '0 : presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`else
    assign presc_term = 1'b1;
`endif

    assign step     = want_step && presc_term;
    assign at_top   = (q_reg == MAX_Q);
    assign at_bot   = (q_reg == '0);
    assign boundary = dir ? at_top : at_bot;

    // Flags the edge on which a boundary action would happen, regardless of mode.
    assign tc = en && presc_term && ((dir && at_top) || (!dir && at_bot));

    always_comb begin
        q_next     = q_reg;
        wrap_next  = 1'b0;
        ovf_next   = ovf_reg;
        state_next = state_reg;

        if (load) begin
            q_next     = (load_val > MAX_Q) ? MAX_Q : load_val;
            state_next = ST_IDLE;
        end else if (start_ok) begin
            state_next = ST_RUN;
            q_next     = dir ? '0 : MAX_Q;
        end else if (step) begin
            if (!boundary) begin
                q_next = dir ? q_reg + 1'b1 : q_reg - 1'b1;
            end else if (oneshot) begin
                // One-shot finishes at the boundary and holds the count.
                state_next = ST_DONE;
            end else begin
                ovf_next = 1'b1;
                if (!saturate) begin
                    q_next    = dir ? '0 : MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end

        // Leaving one-shot mode parks the FSM so busy drops next cycle.
        if (!oneshot) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign q      = q_reg;
    assign wrap_p = wrap_reg;
    assign ovf    = ovf_reg;
    assign busy   = (state_reg == ST_RUN);

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised up/down modulo counter; successor to the fixed 4-bit clear/count counter.
- Adds configurable width and modulus, direction control, parallel load, and count enable.
- Supports three boundary modes (wrap, saturate, one-shot) with terminal-count, wrap and sticky-overflow flags.
- Used as a general event/timing counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MAX_VAL, 9, highest count value; count range is 0..MAX_VAL; must satisfy MAX_VAL <= 2^WIDTH-1 and MAX_VAL >= 1.
- PRESCALE, 4, enabled cycles per count step (2..256); used only with MOD_COUNTER_PRESCALE_EN.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- en  in  1  count enable.
- dir  in  1  1 = count up, 0 = count down.
- mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- start  in  1  one-shot arm/restart strobe (ignored in other modes).
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational).
- wrap_p  out  1  one-cycle registered pulse on wrap-around.
- ovf  out  1  sticky registered boundary-crossing flag.
- busy  out  1  one-shot RUN state indicator (registered).

Behaviour:
- Clock and reset: one clock, `clock`; reset `clear` is synchronous, active-high. Reset takes effect only on a rising edge of `clock`.
- Reset values on the edge where clear=1: q=0, wrap_p=0, ovf=0, busy=0, FSM=IDLE, prescaler=0.
- Priority per edge: clear > load > start > count step.
- Load:
  - q <= load_val, clamped to MAX_VAL if load_val > MAX_VAL.
  - ovf is unchanged. wrap_p=0 on the load edge.
  - In one-shot mode, load forces FSM to IDLE.
- Step condition: en=1 and (mode != one-shot or FSM=RUN); with the prescaler compiled in, the prescaler must also be at its terminal value.
- Up step: q < MAX_VAL -> q+1. At q = MAX_VAL:
  - wrap: q <= 0, wrap_p=1, ovf<=1.
  - saturate: q holds at MAX_VAL, ovf<=1, wrap_p=0.
  - one-shot: q holds, FSM RUN -> DONE.
- Down step: mirror of up step. q > 0 -> q-1. At q = 0:
  - wrap: q <= MAX_VAL, wrap_p=1, ovf<=1.
  - saturate: q holds at 0, ovf<=1.
  - one-shot: q holds, FSM -> DONE.
- Arithmetic: modulo MAX_VAL+1, never modulo 2^WIDTH; q is never > MAX_VAL.
- tc = en & ((dir & q==MAX_VAL) | (~dir & q==0)). Independent of mode; asserts in the cycle before the boundary action.
- wrap_p: high for exactly the one cycle following a wrap edge; otherwise 0.
- ovf: set only by a boundary step in wrap/saturate modes; cleared only by clear.
- One-shot FSM (states IDLE, RUN, DONE):
  - IDLE: start=1 -> RUN, q <= (dir ? 0 : MAX_VAL).
  - RUN: counts on step condition; boundary reached -> DONE.
  - DONE: q holds; start=1 -> RUN with the same preset as from IDLE.
  - start while already in RUN is ignored.
  - busy = (FSM==RUN).
- Mode change mid-count: takes effect on the next edge. If mode leaves one-shot, FSM returns to IDLE and busy drops the next cycle.
- dir change mid-count: takes effect on the next step; no preset.
- Simultaneous load & start: load wins and FSM goes to IDLE.
- Simultaneous clear with anything: clear wins.

Optional Feature:
- Macro: MOD_COUNTER_PRESCALE_EN.
- Defined:
  - Internal prescaler of ceil(log2(PRESCALE)) bits.
  - Advances on each edge where en=1 and the counter would otherwise step; wraps at PRESCALE-1, and the count steps only on that edge.
  - Prescaler resets to 0 on clear, load, and start (one-shot), and holds when en=0.
  - tc additionally requires the prescaler to be at PRESCALE-1.
- Undefined: no prescaler logic; q steps on every enabled cycle; PRESCALE is ignored.

Test Plan:
- WIDTH=4, MAX_VAL=9, wrap, dir=1, en=1 from reset -> q runs 0..9 then 0; tc high while q=9; wrap_p high one cycle with q=0; ovf=1 thereafter.
- Saturate, dir=0, load_val=2, load then en=1 for 5 cycles -> q=2,1,0,0,0; ovf=1 after the first step at 0; wrap_p never asserts.
- One-shot, dir=1, start pulse, en=1 -> busy=1, q 0..9, then DONE with q=9 held and busy=0; second start -> q=0, busy=1.
- load_val=15 with MAX_VAL=9 -> q=9. Simultaneous load=1 and start=1 in one-shot -> q=load value, busy=0. clear=1 on the same edge as load -> q=0.
- Mid-count clear at q=6 (synchronous) -> q=0, ovf=0, busy=0 on that edge only. Asserting and deasserting clear between edges has no effect.
- With MOD_COUNTER_PRESCALE_EN, PRESCALE=4, wrap, dir=1 -> q increments every 4th enabled cycle; en=0 for 3 cycles mid-period delays the step by exactly 3 cycles.
